// File: rtl/r4_pkg.sv
// Shared definitions for the radix-4 butterfly sequencer: default width,
// bin select codes and the sequencer state encoding.
package r4_pkg;

    localparam int unsigned W_DEF = 4;

    localparam logic [2:0] SEL_BIN0 = 3'b000;
    localparam logic [2:0] SEL_BIN1 = 3'b001;
    localparam logic [2:0] SEL_BIN2 = 3'b010;
    localparam logic [2:0] SEL_BIN3 = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [2:0] sel_code(input logic [1:0] bin);
        case (bin)
            2'd0:    return SEL_BIN0;
            2'd1:    return SEL_BIN1;
            2'd2:    return SEL_BIN2;
            default: return SEL_BIN3;
        endcase
    endfunction

endpackage

// File: rtl/r4_butter_seq_if.sv
// Result stream from the sequencer to the downstream reader (valid/ready).
interface r4_butter_seq_if #(parameter int unsigned W = 4);

    logic         out_valid_o;
    logic         out_ready_i;
    logic [1:0]   out_bin_o;
    logic [W-1:0] out_re_o;
    logic [W-1:0] out_im_o;

    modport master (
        output out_valid_o, out_bin_o, out_re_o, out_im_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o, out_bin_o, out_re_o, out_im_o,
        output out_ready_i
    );

endinterface

// File: rtl/r4_result_buf.sv
// Four-entry complex result store: one write port, one asynchronous read port.
module r4_result_buf #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_we,
    input  logic [1:0]   i_waddr,
    input  logic [W-1:0] i_wre,
    input  logic [W-1:0] i_wim,
    input  logic [1:0]   i_raddr,
    output logic [W-1:0] o_rre,
    output logic [W-1:0] o_rim
);

    logic [W-1:0] r_re [4];
    logic [W-1:0] r_im [4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (i_we) begin
            r_re[i_waddr] <= i_wre;
            r_im[i_waddr] <= i_wim;
        end
    end

    assign o_rre = r_re[i_raddr];
    assign o_rim = r_im[i_raddr];

endmodule

// File: rtl/r4_butter_seq.sv
// Radix-4 butterfly sequencer: latches a 4-sample frame, sweeps the bin
// select, captures each bin result after SETTLE cycles, then streams results.
module r4_butter_seq
    import r4_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned SETTLE = 2
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [4*W-1:0] in_re_i,
    input  logic [4*W-1:0] in_im_i,
    output logic           start_rdy_o,
    output logic [4*W-1:0] xr_o,
    output logic [4*W-1:0] xi_o,
    output logic [2:0]     c_o,
    input  logic [W-1:0]   xro_i,
    input  logic [W-1:0]   xio_i,
    r4_butter_seq_if.master out_if,
    output logic           busy_o,
    output logic           done_o,
    output logic [7:0]     frames_o
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t         r_state;
    logic [1:0]     r_bin;
    logic [3:0]     r_cnt;
    logic [1:0]     r_beat;
    logic           r_valid;
    logic [2:0]     r_c;
    logic [4*W-1:0] r_xr;
    logic [4*W-1:0] r_xi;
    logic           r_done;
    logic [7:0]     r_frames;
    logic           r_busy;
    logic           r_rdy;

    logic           w_cap;
    logic           w_accept;

    // Capture is suppressed by abort so an aborted sweep leaves no partial write.
    assign w_cap    = (r_state == SWEEP) && (r_cnt == CNT_LAST) && !abort_i;
    assign w_accept = r_valid && out_if.out_ready_i;

    r4_result_buf #(.W(W)) u_buf (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_we    (w_cap),
        .i_waddr (r_bin),
        .i_wre   (xro_i),
        .i_wim   (xio_i),
        .i_raddr (r_beat),
        .o_rre   (out_if.out_re_o),
        .o_rim   (out_if.out_im_o)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= IDLE;
            r_bin    <= '0;
            r_cnt    <= '0;
            r_beat   <= '0;
            r_valid  <= 1'b0;
            r_c      <= SEL_BIN0;
            r_xr     <= '0;
            r_xi     <= '0;
            r_done   <= 1'b0;
            r_frames <= '0;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        r_xr    <= in_re_i;
                        r_xi    <= in_im_i;
                        r_bin   <= '0;
                        r_cnt   <= '0;
                        r_c     <= SEL_BIN0;
                        r_busy  <= 1'b1;
                        r_rdy   <= 1'b0;
                        r_state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (abort_i) begin
                        r_c     <= SEL_BIN0;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_bin == 2'd3) begin
                            r_beat  <= '0;
                            r_valid <= 1'b1;
                            r_c     <= SEL_BIN0;
                            r_state <= DRAIN;
                        end else begin
                            r_bin <= r_bin + 2'd1;
                            r_c   <= sel_code(r_bin + 2'd1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (abort_i) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        if (r_beat == 2'd3) begin
                            r_valid  <= 1'b0;
                            r_done   <= 1'b1;
                            r_frames <= r_frames + 8'd1;
                            r_busy   <= 1'b0;
                            r_rdy    <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_rdy_o        = r_rdy;
    assign xr_o               = r_xr;
    assign xi_o               = r_xi;
    assign c_o                = r_c;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign frames_o           = r_frames;
    assign out_if.out_valid_o = r_valid;
    assign out_if.out_bin_o   = r_beat;

endmodule

// File: tb/tb_r4_butter_seq.sv
// Directed bench for r4_butter_seq with a behavioural radix-4 butterfly on
// the select/sample outputs; expected bin results are hand-computed constants.
module tb_r4_butter_seq;

    localparam int unsigned W      = 4;
    localparam int unsigned SETTLE = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [4*W-1:0] in_re;
    logic [4*W-1:0] in_im;
    logic           start_rdy;
    logic [4*W-1:0] xr;
    logic [4*W-1:0] xi;
    logic [2:0]     c;
    logic [W-1:0]   xro;
    logic [W-1:0]   xio;
    logic           busy;
    logic           done;
    logic [7:0]     frames;

    int n_checks = 0;
    int n_fail   = 0;

    r4_butter_seq_if #(.W(W)) out_if ();

    r4_butter_seq #(.W(W), .SETTLE(SETTLE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start),
        .abort_i     (abort),
        .in_re_i     (in_re),
        .in_im_i     (in_im),
        .start_rdy_o (start_rdy),
        .xr_o        (xr),
        .xi_o        (xi),
        .c_o         (c),
        .xro_i       (xro),
        .xio_i       (xio),
        .out_if      (out_if),
        .busy_o      (busy),
        .done_o      (done),
        .frames_o    (frames)
    );

    always #5 clk = ~clk;

    // Butterfly: X[k] = sum_n x[n] * (-j)^(n*k), wrapped to W bits.
    int m_xr [4];
    int m_xi [4];
    int m_re;
    int m_im;
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            m_xr[k] = int'($signed(xr[k*W +: W]));
            m_xi[k] = int'($signed(xi[k*W +: W]));
        end
        m_re = 0;
        m_im = 0;
        case (c)
            3'b000: begin
                m_re = m_xr[0] + m_xr[1] + m_xr[2] + m_xr[3];
                m_im = m_xi[0] + m_xi[1] + m_xi[2] + m_xi[3];
            end
            3'b001: begin
                m_re = m_xr[0] + m_xi[1] - m_xr[2] - m_xi[3];
                m_im = m_xi[0] - m_xr[1] - m_xi[2] + m_xr[3];
            end
            3'b010: begin
                m_re = m_xr[0] - m_xr[1] + m_xr[2] - m_xr[3];
                m_im = m_xi[0] - m_xi[1] + m_xi[2] - m_xi[3];
            end
            3'b100: begin
                m_re = m_xr[0] - m_xi[1] - m_xr[2] + m_xi[3];
                m_im = m_xi[0] + m_xr[1] - m_xi[2] - m_xr[3];
            end
            default: ;
        endcase
        xro = m_re[W-1:0];
        xio = m_im[W-1:0];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input string tag);
        logic [11:0] codes;
        codes = {3'b100, 3'b010, 3'b001, 3'b000};
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < int'(SETTLE); s++) begin
                check_eq({tag, "_c"}, 32'(c), 32'(codes[b*3 +: 3]));
                tick();
            end
        end
    endtask

    task automatic beat_check(input string tag, input int b, input logic [15:0] er, input logic [15:0] ei);
        check_eq({tag, "_valid"}, 32'(out_if.out_valid_o), 32'd1);
        check_eq({tag, "_bin"},   32'(out_if.out_bin_o),   32'(b));
        check_eq({tag, "_re"},    32'(out_if.out_re_o),    32'(er[b*4 +: 4]));
        check_eq({tag, "_im"},    32'(out_if.out_im_o),    32'(ei[b*4 +: 4]));
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_eq({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int got;
        int t_done [3];
        bit seen;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_re = '0;
        in_im = '0;
        out_if.out_ready_i = 1'b0;
        tick();
        tick();
        check_eq("rst_valid",  32'(out_if.out_valid_o), 32'd0);
        check_eq("rst_c",      32'(c),         32'd0);
        check_eq("rst_busy",   32'(busy),      32'd0);
        check_eq("rst_rdy",    32'(start_rdy), 32'd1);
        check_eq("rst_frames", 32'(frames),    32'd0);
        check_eq("rst_xr",     32'(xr),        32'd0);
        check_eq("rst_re",     32'(out_if.out_re_o), 32'd0);
        rst = 1'b0;
        tick();

        // Reset while bin 2 is selected
        in_re = 16'h4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("t1_c_bin2", 32'(c), 32'h2);
        rst = 1'b1;
        #2;
        check_eq("t1_valid",  32'(out_if.out_valid_o), 32'd0);
        check_eq("t1_c",      32'(c),         32'd0);
        check_eq("t1_busy",   32'(busy),      32'd0);
        check_eq("t1_rdy",    32'(start_rdy), 32'd1);
        check_eq("t1_frames", 32'(frames),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Frame re={1,2,3,4}, im=0: bins (A,0) (E,2) (E,0) (E,E)
        in_re = 16'h4321;
        in_im = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t2_xr",   32'(xr),        32'h4321);
        check_eq("t2_busy", 32'(busy),      32'd1);
        check_eq("t2_rdy",  32'(start_rdy), 32'd0);
        sweep_check("t2");
        out_if.out_ready_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            beat_check("t2", b, 16'hEEEA, 16'hE020);
            check_eq("t2_nodone", 32'(done), 32'd0);
            tick();
        end
        check_eq("t2_done",   32'(done),   32'd1);
        check_eq("t2_frames", 32'(frames), 32'd1);
        check_eq("t2_idle_valid", 32'(out_if.out_valid_o), 32'd0);
        check_eq("t2_idle_rdy",   32'(start_rdy), 32'd1);
        tick();
        check_eq("t2_done_pulse", 32'(done), 32'd0);
        out_if.out_ready_i = 1'b0;

        // Frame x0=1, x1=j: bins (1,1) (2,0) (1,F) (0,0); stall on beat 1
        in_re = 16'h0001;
        in_im = 16'h0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        sweep_check("t3");
        out_if.out_ready_i = 1'b1;
        beat_check("t3_b0", 0, 16'h0121, 16'h0F01);
        tick();
        out_if.out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            beat_check("t3_hold", 1, 16'h0121, 16'h0F01);
            tick();
        end
        out_if.out_ready_i = 1'b1;
        for (int b = 1; b < 4; b++) begin
            beat_check("t3", b, 16'h0121, 16'h0F01);
            tick();
        end
        check_eq("t3_done",   32'(done),   32'd1);
        check_eq("t3_frames", 32'(frames), 32'd2);

        // Abort on beat 2
        in_re = 16'h4321;
        in_im = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4 * SETTLE) tick();
        tick();
        tick();
        check_eq("t4_bin2", 32'(out_if.out_bin_o), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t4_valid",  32'(out_if.out_valid_o), 32'd0);
        check_eq("t4_busy",   32'(busy),      32'd0);
        check_eq("t4_rdy",    32'(start_rdy), 32'd1);
        check_eq("t4_done",   32'(done),      32'd0);
        check_eq("t4_c",      32'(c),         32'd0);
        check_eq("t4_frames", 32'(frames),    32'd2);
        tick();
        check_eq("t4_done2",   32'(done),   32'd0);
        check_eq("t4_frames2", 32'(frames), 32'd2);

        // Abort and start together in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_eq("t4_abst_busy", 32'(busy),      32'd0);
        check_eq("t4_abst_rdy",  32'(start_rdy), 32'd1);

        // Back-to-back frames with start held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        out_if.out_ready_i = 1'b1;
        start = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && got < 3; i++) begin
            tick();
            if (done) begin
                t_done[got] = i;
                got++;
            end
        end
        start = 1'b0;
        check_eq("t5_dones",  32'(got),    32'd3);
        check_eq("t5_frames", 32'(frames), 32'd3);
        check_eq("t5_gap1",   32'(t_done[1] - t_done[0]), 32'd13);
        check_eq("t5_gap2",   32'(t_done[2] - t_done[1]), 32'd13);
        tick();
        check_eq("t5_idle", 32'(busy), 32'd0);

        // start during SWEEP is ignored
        in_re = 16'h4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        in_re = 16'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t6_xr_held", 32'(xr), 32'h4321);
        check_eq("t6_c_bin1",  32'(c),  32'h1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_if.out_valid_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("t6_valid_seen", 32'(seen), 32'd1);
        check_eq("t6_b0_re", 32'(out_if.out_re_o), 32'hA);
        wait_done("t6", 10);
        check_eq("t6_frames", 32'(frames), 32'd4);

        // Run to frame counter wrap
        start = 1'b1;
        got = 0;
        for (int i = 0; i < 4000 && got < 252; i++) begin
            tick();
            if (done) begin
                got++;
                if (got == 251) check_eq("t6_frames_255", 32'(frames), 32'd255);
            end
        end
        start = 1'b0;
        check_eq("t6_wrap_dones",  32'(got),    32'd252);
        check_eq("t6_wrap_frames", 32'(frames), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
